// File: rtl/divider32.sv
// divider32: 32-bit sequential restoring divider; in clk, reset, op_start, op_clear, dividend[32], divisor[32]; out quotient[32], remainder[32], op_done, busy, div_by_zero
module divider32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        op_done,
    output logic        busy,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_n;
    logic [31:0] q, r, d, q_n, r_n, d_n, quo_n, rem_n, q_step, r_step;
    logic [4:0] cnt, cnt_n;
    logic done_n, busy_n, dz_n, zero_div, ge, unused_diff_msb;
    logic [32:0] s;
    logic [33:0] diff;
    always_comb begin
        s = {r, q[31]};
        diff = {1'b0, s} + {1'b0, ~{1'b0, d}} + 34'd1;
        ge = diff[33];
        unused_diff_msb = diff[32];
        r_step = ge ? diff[31:0] : s[31:0];
        q_step = {q[30:0], ge};
        zero_div = divisor == '0;
    end
    always_comb begin
        state_n = state;
        q_n = q;
        r_n = r;
        d_n = d;
        cnt_n = cnt;
        quo_n = quotient;
        rem_n = remainder;
        done_n = op_done;
        busy_n = busy;
        dz_n = div_by_zero;
        if (op_clear) begin
            state_n = IDLE;
            quo_n = '0;
            rem_n = '0;
            done_n = 1'b0;
            busy_n = 1'b0;
            dz_n = 1'b0;
        end else if (state != EXEC && op_start) begin
            q_n = dividend;
            d_n = divisor;
            r_n = '0;
            cnt_n = '0;
            state_n = zero_div ? DONE : EXEC;
            done_n = zero_div;
            busy_n = !zero_div;
            dz_n = zero_div;
            quo_n = zero_div ? '1 : '0;
            rem_n = zero_div ? dividend : '0;
        end else if (state == EXEC) begin
            q_n = q_step;
            r_n = r_step;
            cnt_n = cnt + 5'd1;
            state_n = cnt == 5'd31 ? DONE : EXEC;
            busy_n = cnt != 5'd31;
            done_n = cnt == 5'd31;
            quo_n = cnt == 5'd31 ? q_step : '0;
            rem_n = cnt == 5'd31 ? r_step : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q <= '0;
            r <= '0;
            d <= '0;
            cnt <= '0;
            quotient <= '0;
            remainder <= '0;
            op_done <= 1'b0;
            busy <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_n;
            q <= q_n;
            r <= r_n;
            d <= d_n;
            cnt <= cnt_n;
            quotient <= quo_n;
            remainder <= rem_n;
            op_done <= done_n;
            busy <= busy_n;
            div_by_zero <= dz_n;
        end
    end
endmodule

// File: tb/tb_divider32.sv
// tb_divider32: table, random and corner-sequence checks of divider32 against an arithmetic model
module tb_divider32;
    logic clk = 1'b0;
    logic reset, op_start, op_clear;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic op_done, busy, div_by_zero;
    int n_cmp = 0;
    int n_err = 0;

    divider32 dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_clear(op_clear),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .op_done(op_done), .busy(busy), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, q, r;
        logic dz;
    } vec_t;
    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " quotient"}, 64'(quotient), 64'd0);
        check({name, " remainder"}, 64'(remainder), 64'd0);
        check({name, " op_done"}, 64'(op_done), 64'd0);
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " div_by_zero"}, 64'(div_by_zero), 64'd0);
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        dz = b == 0;
        q = dz ? 32'hFFFF_FFFF : a / b;
        r = dz ? a : a % b;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor = b;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!op_done && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_clear();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check_idle("clear");
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int lat;
        start_op(a, b);
        if (edz) begin
            check({name, " dz op_done"}, 64'(op_done), 64'd1);
            check({name, " dz busy"}, 64'(busy), 64'd0);
        end else begin
            check({name, " busy"}, 64'(busy), 64'd1);
            check({name, " op_done early"}, 64'(op_done), 64'd0);
            wait_done(lat);
            check({name, " latency"}, 64'(lat), 64'd32);
            check({name, " busy after"}, 64'(busy), 64'd0);
        end
        check({name, " quotient"}, 64'(quotient), 64'(eq));
        check({name, " remainder"}, 64'(remainder), 64'(er));
        check({name, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    endtask

    initial begin
        int lat, seen;
        logic [31:0] a, b, eq, er;
        logic edz;
        tbl[0] = '{a: 32'd100, b: 32'd7, q: 32'd14, r: 32'd2, dz: 1'b0};
        tbl[1] = '{a: 32'hFFFF_FFFF, b: 32'd1, q: 32'hFFFF_FFFF, r: 32'd0, dz: 1'b0};
        tbl[2] = '{a: 32'hFFFF_FFFF, b: 32'h8000_0000, q: 32'd1, r: 32'h7FFF_FFFF, dz: 1'b0};
        tbl[3] = '{a: 32'd5, b: 32'd9, q: 32'd0, r: 32'd5, dz: 1'b0};
        tbl[4] = '{a: 32'd1234, b: 32'd0, q: 32'hFFFF_FFFF, r: 32'd1234, dz: 1'b1};
        tbl[5] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, q: 32'd1, r: 32'd0, dz: 1'b0};
        reset = 1'b1;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
            tick();
            tick();
            check($sformatf("tbl%0d hold done", i), 64'(op_done), 64'd1);
            check($sformatf("tbl%0d hold q", i), 64'(quotient), 64'(tbl[i].q));
            do_clear();
        end

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 10 == 7) b = 0;
            model(a, b, eq, er, edz);
            run_vec($sformatf("rnd%0d", i), a, b, eq, er, edz);
            if (i % 3 == 0) do_clear();
        end
        do_clear();

        start_op(32'd1000, 32'd3);
        repeat (4) tick();
        dividend = 32'd50;
        divisor = 32'd5;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        check("ignored start busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("ignored start latency", 64'(lat), 64'd27);
        check("ignored start quotient", 64'(quotient), 64'd333);
        check("ignored start remainder", 64'(remainder), 64'd1);

        start_op(32'd81, 32'd9);
        check("restart op_done drop", 64'(op_done), 64'd0);
        check("restart busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("restart latency", 64'(lat), 64'd32);
        check("restart quotient", 64'(quotient), 64'd9);
        check("restart remainder", 64'(remainder), 64'd0);

        dividend = 32'd77;
        divisor = 32'd7;
        op_start = 1'b1;
        op_clear = 1'b1;
        tick();
        op_start = 1'b0;
        op_clear = 1'b0;
        check_idle("clear beats start");
        tick();
        check("clear beats start stays idle", 64'(busy), 64'd0);

        start_op(32'd1000, 32'd3);
        repeat (9) tick();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check_idle("abort");
        seen = 0;
        repeat (40) begin
            tick();
            seen += int'(op_done) + int'(busy);
        end
        check("abort no done", 64'(seen), 64'd0);

        start_op(32'd4000, 32'd7);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset mid exec");
        seen = 0;
        repeat (40) begin
            tick();
            seen += int'(op_done);
        end
        check("reset no done", 64'(seen), 64'd0);

        run_vec("after reset", 32'd4000, 32'd7, 32'd571, 32'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
